// File: rtl/axis_s2mm_framer.sv
// -----------------------------------------------------------------------------
// axis_s2mm_framer
//
// Takes 128-bit sample beats from the weighting multiplier on AXI-Stream and
// forwards them to the S2MM DMA channel, cut into frames of a programmable
// beat count. tlast is generated when the frame length is reached or when the
// upstream marks an early end with s_axis_tlast. A 2-entry buffer absorbs DMA
// backpressure, so s_axis_tready depends only on registered state. Dropping
// enable lets the current frame finish before the block returns to idle.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            asynchronous, active-high reset
//   enable         run request; low = finish current frame, then stop
//   frame_len      beats per frame, sampled at each frame start (0 -> 1)
//   s_axis_tdata   upstream beat data
//   s_axis_tvalid  upstream beat valid
//   s_axis_tlast   upstream end-of-frame (forces an early frame end)
//   s_axis_tready  framer can accept a beat
//   m_axis_tdata   beat to S2MM
//   m_axis_tkeep   byte enables, all ones while m_axis_tvalid is high
//   m_axis_tlast   last beat of a frame
//   m_axis_tvalid  output beat valid
//   m_axis_tready  S2MM accepts the beat
//   frame_count    frames completed downstream, wraps
//   busy           not idle, or beats still buffered
// -----------------------------------------------------------------------------
module axis_s2mm_framer #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [LEN_W-1:0]  frame_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   beat_cnt_d;
  logic [LEN_W-1:0]   len_load;

  // Buffer: each entry holds {last, data}.
  logic [DATA_W:0]    mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic [DATA_W:0]    head;

  logic               push, pop, last_gen;

  // ---------------------------------------------------------------------------
  // Handshakes and frame boundary detection
  // ---------------------------------------------------------------------------
  assign s_axis_tready = ((state_q == RUN) || (state_q == STOP)) && (count != 2'd2);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_gen      = s_axis_tlast || (beat_cnt == (len_q - LEN_W'(1)));
  assign len_load      = (frame_len == '0) ? LEN_W'(1) : frame_len;

  always_comb begin
    beat_cnt_d = beat_cnt;
    if (push) begin
      beat_cnt_d = last_gen ? '0 : beat_cnt + LEN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // The RUN exit uses the post-handshake beat count so a beat accepted in the
  // same cycle enable drops is accounted for: if it closes the frame we go
  // straight to IDLE, otherwise STOP waits for the frame's last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable) state_d = (beat_cnt_d == '0) ? IDLE : STOP;
      end
      STOP: if (push && last_gen) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= LEN_W'(1);
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
      if ((state_q == IDLE) && enable) begin
        len_q <= len_load;
      end else if (push && last_gen) begin
        len_q <= len_load;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry buffer
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed while count says it is occupied, and outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {last_gen, s_axis_tdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[DATA_W];
  assign m_axis_tkeep  = {KEEP_W{m_axis_tvalid}};

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (pop && m_axis_tlast) begin
      frame_count <= frame_count + LEN_W'(1);
    end
  end

  assign busy = (state_q != IDLE) || (count != 2'd0);

endmodule
